// File: rtl/mda_motor_cmd_ramp_if.sv
// Host command channel for the motor command ramp stage: valid/ready handshake
// carrying the requested on/period/duty fields.
interface mda_motor_cmd_ramp_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_on;
  logic [DATA_W-1:0] cmd_period;
  logic [DATA_W-1:0] cmd_duty;

  modport master (output cmd_valid, cmd_on, cmd_period, cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, cmd_on, cmd_period, cmd_duty, output cmd_ready);
endinterface

// File: rtl/mda_motor_cmd_ramp.sv
// Motor command stage: accepts host commands and slews duty_cycle toward the target
// so the H-bridge never sees a step. Optional watchdog: define MDA_MOTOR_CMD_RAMP_WDT_EN.
module mda_motor_cmd_ramp #(
  parameter int          DATA_W     = 16,
  parameter int unsigned STEP_DIV   = 1000,
  parameter logic [15:0] STEP       = 16'd16,
  parameter int unsigned WDT_CYCLES = 50000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mda_motor_cmd_ramp_if.slave  s_cmd,
  output logic                 o_on,
  output logic [DATA_W-1:0]    o_period,
  output logic [DATA_W-1:0]    o_duty_cycle,
  output logic                 o_ramping,
  output logic                 o_wdt_tripped
);

  typedef enum logic [1:0] {S_OFF, S_RAMP, S_HOLD, S_DRAIN} state_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(STEP_DIV - 1);

  if (STEP_DIV == 0 || STEP == '0 || WDT_CYCLES == 0) begin : g_param_chk
    $error("mda_motor_cmd_ramp: STEP_DIV, STEP and WDT_CYCLES must be >= 1");
  end

  // One ramp tick toward tgt; the 17-bit difference keeps the step from wrapping or overshooting.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                             input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] diff;
    if ({1'b0, cur} < {1'b0, tgt}) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      slew = (diff > {1'b0, STEP}) ? cur + STEP : tgt;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      slew = (diff > {1'b0, STEP}) ? cur - STEP : tgt;
    end
  endfunction

  state_t            r_state;
  logic [PW-1:0]     r_presc;
  logic              r_on;
  logic [DATA_W-1:0] r_period;
  logic [DATA_W-1:0] r_duty;
  logic [DATA_W-1:0] r_target;
  logic              r_pend_on;
  logic [DATA_W-1:0] r_pend_period;
  logic [DATA_W-1:0] r_pend_target;

  logic              w_tick;
  logic              w_acc;
  logic              w_on_req;
  logic [DATA_W-1:0] w_tgt;
  logic [DATA_W-1:0] w_slewed;
  logic              w_wdt_exp;

  assign w_tick   = (r_presc == TICK_AT);
  assign w_acc    = s_cmd.cmd_valid & s_cmd.cmd_ready;
  assign w_on_req = s_cmd.cmd_on & (s_cmd.cmd_period != '0);
  assign w_tgt    = (s_cmd.cmd_duty > s_cmd.cmd_period) ? s_cmd.cmd_period : s_cmd.cmd_duty;
  assign w_slewed = slew(r_duty, r_target);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_presc <= '0;
    else         r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_OFF;
      r_on          <= 1'b0;
      r_period      <= '0;
      r_duty        <= '0;
      r_target      <= '0;
      r_pend_on     <= 1'b0;
      r_pend_period <= '0;
      r_pend_target <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (w_acc && w_on_req) begin
            r_on     <= 1'b1;
            r_period <= s_cmd.cmd_period;
            r_duty   <= '0;
            r_target <= w_tgt;
            r_state  <= S_RAMP;
          end
        end
        S_RAMP, S_HOLD: begin
          if (w_tick) r_duty <= w_slewed;
          if (w_acc) begin
            if (w_on_req && (s_cmd.cmd_period == r_period)) begin
              r_target <= w_tgt;
              r_state  <= S_RAMP;
            end else begin
              // Period change or turn-off: park the request until duty reaches zero.
              r_pend_on     <= w_on_req;
              r_pend_period <= s_cmd.cmd_period;
              r_pend_target <= w_tgt;
              r_target      <= '0;
              r_state       <= S_DRAIN;
            end
          end else if (w_wdt_exp) begin
            r_pend_on <= 1'b0;
            r_target  <= '0;
            r_state   <= S_DRAIN;
          end else if (r_duty == r_target) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_RAMP;
          end
        end
        S_DRAIN: begin
          if (w_tick) begin
            r_duty <= w_slewed;
            if (w_slewed == '0) begin
              if (r_pend_on) begin
                r_period <= r_pend_period;
                r_target <= r_pend_target;
                r_state  <= S_RAMP;
              end else begin
                r_on    <= 1'b0;
                r_state <= S_OFF;
              end
            end
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

`ifdef MDA_MOTOR_CMD_RAMP_WDT_EN
  logic [31:0] r_wdt_cnt;
  logic        r_wdt_trip;

  assign w_wdt_exp = (r_wdt_cnt >= WDT_CYCLES - 1);

  // Counter saturates at expiry so a long drain cannot wrap it back to safe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else begin
      if (w_acc || r_state == S_OFF) r_wdt_cnt <= '0;
      else if (!w_wdt_exp)           r_wdt_cnt <= r_wdt_cnt + 32'd1;
      if (w_acc)
        r_wdt_trip <= 1'b0;
      else if (w_wdt_exp && (r_state == S_RAMP || r_state == S_HOLD))
        r_wdt_trip <= 1'b1;
    end
  end

  assign o_wdt_tripped = r_wdt_trip;
`else
  assign w_wdt_exp     = 1'b0;
  assign o_wdt_tripped = 1'b0;
`endif

  assign s_cmd.cmd_ready = (r_state != S_DRAIN);
  assign o_on            = r_on;
  assign o_period        = r_period;
  assign o_duty_cycle    = r_duty;
  assign o_ramping       = (r_duty != r_target) || (r_state == S_DRAIN);

endmodule
